// File: rtl/seg_pkg.sv
// Segment pattern constants shared by the encoder and the scan driver.
// Bit order is gfedcba in [6:0]; the decimal point is bit 7 of the full drive byte.
package seg_pkg;

  localparam logic [6:0] SEG_0 = 7'h3f;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5b;
  localparam logic [6:0] SEG_3 = 7'h4f;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6d;
  localparam logic [6:0] SEG_6 = 7'h7d;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7f;
  localparam logic [6:0] SEG_9 = 7'h6f;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7c;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5e;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  localparam logic [7:0]  SEG_OFF    = 8'h00;
  localparam int unsigned SEG_DP_BIT = 7;

endpackage

// File: rtl/hex_seg_scan_if.sv
// Host-side bundle of the scan driver: value/flag load inputs and the pin-facing outputs.
interface hex_seg_scan_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  en;
  logic                  load;
  logic [4*DIGITS-1:0]   hex_in;
  logic [DIGITS-1:0]     dp_in;
  logic [DIGITS-1:0]     blank_in;
  logic [7:0]            seg;
  logic [DIGITS-1:0]     dig_sel;
  logic                  frame_done;

  modport master (
    output en, load, hex_in, dp_in, blank_in,
    input  seg, dig_sel, frame_done
  );

  modport slave (
    input  en, load, hex_in, dp_in, blank_in,
    output seg, dig_sel, frame_done
  );
endinterface

// File: rtl/hex_seg.sv
// Combinational hex nibble to gfedcba pattern; every nibble value lights something.
module hex_seg
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    unique case (nib_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'ha: seg_o = SEG_A;
      4'hb: seg_o = SEG_B;
      4'hc: seg_o = SEG_C;
      4'hd: seg_o = SEG_D;
      4'he: seg_o = SEG_E;
      4'hf: seg_o = SEG_F;
    endcase
  end

endmodule

// File: rtl/hex_seg_scan.sv
// Multiplexed common-cathode 7-segment driver with a double-buffered display value.
// Pending data moves to the display only at frame boundaries or while scanning is off.
module hex_seg_scan
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 50000
) (
  input logic             clk,
  input logic             rst_n,
  hex_seg_scan_if.slave   bus
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PMax = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IMax = IW'(DIGITS - 1);

  logic [PW-1:0]         p_q, p_d;
  logic [IW-1:0]         i_q, i_d;
  logic [4*DIGITS-1:0]   pend_hex_q, pend_hex_d, disp_hex_q, disp_hex_d;
  logic [DIGITS-1:0]     pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic [DIGITS-1:0]     pend_blank_q, pend_blank_d, disp_blank_q, disp_blank_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [7:0]            seg_q, seg_d;
  logic [DIGITS-1:0]     dig_q, dig_d;
  logic                  fd_q, fd_d;

  logic [3:0]            nib;
  logic                  sel_dp, sel_blank;
  logic [6:0]            enc;
  logic                  boundary, swap_ok;

  // Mux the active digit out of the display buffer; only one encoder is needed.
  always_comb begin
    nib       = '0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (i_q == IW'(k)) begin
        nib       = disp_hex_q[4*k +: 4];
        sel_dp    = disp_dp_q[k];
        sel_blank = disp_blank_q[k];
      end
    end
  end

  hex_seg u_enc (
    .nib_i (nib),
    .seg_o (enc)
  );

  always_comb begin
    p_d          = p_q;
    i_d          = i_q;
    pend_hex_d   = pend_hex_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    pend_valid_d = pend_valid_q;
    disp_hex_d   = disp_hex_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;
    seg_d        = SEG_OFF;
    dig_d        = '1;
    fd_d         = 1'b0;

    boundary = bus.en && (p_q == PMax) && (i_q == IMax);
    swap_ok  = boundary || !bus.en;

    if (bus.en) begin
      if (p_q == PMax) begin
        p_d = '0;
        i_d = (i_q == IMax) ? '0 : i_q + IW'(1);
      end else begin
        p_d = p_q + PW'(1);
      end
      // p == 0 is the anti-ghost dead cycle between digits.
      if (p_q != '0) begin
        for (int k = 0; k < DIGITS; k++) dig_d[k] = (i_q != IW'(k));
        if (!sel_blank) begin
          seg_d[6:0]        = enc;
          seg_d[SEG_DP_BIT] = sel_dp;
        end
      end
      fd_d = boundary;
    end

    if (swap_ok) begin
      if (pend_valid_q) begin
        disp_hex_d   = pend_hex_q;
        disp_dp_d    = pend_dp_q;
        disp_blank_d = pend_blank_q;
      end
      pend_valid_d = 1'b0;
    end

    if (bus.load) begin
      pend_hex_d   = bus.hex_in;
      pend_dp_d    = bus.dp_in;
      pend_blank_d = bus.blank_in;
      pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_q          <= '0;
      i_q          <= '0;
      pend_hex_q   <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      pend_valid_q <= 1'b0;
      disp_hex_q   <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '1;
      seg_q        <= SEG_OFF;
      dig_q        <= '1;
      fd_q         <= 1'b0;
    end else begin
      p_q          <= p_d;
      i_q          <= i_d;
      pend_hex_q   <= pend_hex_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      pend_valid_q <= pend_valid_d;
      disp_hex_q   <= disp_hex_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      seg_q        <= seg_d;
      dig_q        <= dig_d;
      fd_q         <= fd_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dig_sel    = dig_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_hex_seg_scan.sv
// Directed plus randomized bench for hex_seg_scan against a time-slot reference model.
module tb_hex_seg_scan;

  localparam int DG = 4;
  localparam int SD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hex_seg_scan_if #(.DIGITS(DG)) bus ();

  hex_seg_scan #(.DIGITS(DG), .SCAN_DIV(SD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [6:0] tbl [16] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
                           7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71};

  // Model: t counts enabled cycles since reset; slot index and digit follow from it.
  int         t;
  logic [3:0] m_phex [DG];
  logic [3:0] m_dhex [DG];
  logic [DG-1:0] m_pdp, m_pbl, m_ddp, m_dbl;
  logic       m_pv;
  logic [7:0] e_seg;
  logic [DG-1:0] e_dig;
  logic       e_fd;

  int checks = 0;
  int errors = 0;
  int fd_cnt;
  logic [7:0] seen [DG];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic tick();
    int p, i;
    logic bnd;
    p = t % SD;
    i = (t / SD) % DG;
    if (!rst_n) begin
      t = 0; m_pv = 1'b0; m_pdp = '0; m_pbl = '0; m_ddp = '0; m_dbl = '1;
      for (int k = 0; k < DG; k++) begin m_phex[k] = '0; m_dhex[k] = '0; end
      e_seg = 8'h00; e_dig = '1; e_fd = 1'b0;
    end else begin
      bnd = bus.en && (p == SD - 1) && (i == DG - 1);
      e_seg = 8'h00; e_dig = '1; e_fd = bnd;
      if (bus.en) begin
        if (p != 0) begin
          e_dig = ~(DG'(1) << i);
          if (!m_dbl[i]) e_seg = {m_ddp[i], tbl[m_dhex[i]]};
        end
        t++;
      end
      if (bnd || !bus.en) begin
        if (m_pv) begin
          for (int k = 0; k < DG; k++) m_dhex[k] = m_phex[k];
          m_ddp = m_pdp; m_dbl = m_pbl;
        end
        m_pv = 1'b0;
      end
      if (bus.load) begin
        for (int k = 0; k < DG; k++) m_phex[k] = bus.hex_in[4*k +: 4];
        m_pdp = bus.dp_in; m_pbl = bus.blank_in; m_pv = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("seg", bus.seg, e_seg);
    chk("dig_sel", 8'(bus.dig_sel), 8'(e_dig));
    chk("frame_done", 8'(bus.frame_done), 8'(e_fd));
    if (bus.frame_done) fd_cnt++;
    for (int k = 0; k < DG; k++) if (bus.dig_sel == ~(DG'(1) << k)) seen[k] = bus.seg;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_load(input logic [15:0] h, input logic [3:0] dp, input logic [3:0] bl);
    bus.hex_in = h; bus.dp_in = dp; bus.blank_in = bl; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
  endtask

  initial begin
    t = 0;
    bus.en = 1'b1; bus.load = 1'b1; bus.hex_in = 16'hbeef; bus.dp_in = '1; bus.blank_in = '0;
    rst_n = 1'b0;
    run(3);
    chk("reset_dig", 8'(bus.dig_sel), 8'h0f);
    chk("reset_seg", bus.seg, 8'h00);
    rst_n = 1'b1; bus.load = 1'b0;
    run(8);

    // Basic scan of 1234
    do_load(16'h1234, 4'b0000, 4'b0000);
    run(2 * DG * SD);
    fd_cnt = 0;
    run(DG * SD);
    chk("fd_per_frame", 8'(fd_cnt), 8'd1);
    chk("basic_d0", seen[0], 8'h66);
    chk("basic_d1", seen[1], 8'h4f);
    chk("basic_d2", seen[2], 8'h5b);
    chk("basic_d3", seen[3], 8'h06);

    // Encoder sweep on digit 0
    for (int v = 0; v < 16; v++) begin
      do_load({4{4'(v)}}, 4'b0000, 4'b0000);
      run(2 * DG * SD);
      chk("sweep_d0", seen[0], {1'b0, tbl[v]});
    end

    // Tearing: mid-frame load, then a load on the boundary edge
    while (t % (DG * SD) != 5) tick();
    do_load(16'habcd, 4'b0000, 4'b0000);
    run(2 * DG * SD);
    chk("tear_d0", seen[0], 8'h5e);
    while (t % (DG * SD) != DG * SD - 1) tick();
    do_load(16'h5678, 4'b0000, 4'b0000);
    run(2 * DG * SD);
    chk("bnd_load_d3", seen[3], 8'h6d);

    // dp and blank
    do_load(16'h8884, 4'b0101, 4'b1000);
    run(2 * DG * SD);
    chk("dpbl_d0", seen[0], 8'he6);
    chk("dpbl_d1", seen[1], 8'h7f);
    chk("dpbl_d2", seen[2], 8'hff);
    chk("dpbl_d3", seen[3], 8'h00);

    // Disable mid-slot, load while dark, resume
    while (t % SD != 2) tick();
    bus.en = 1'b0;
    run(2);
    do_load(16'h0f0f, 4'b0000, 4'b0000);
    run(3);
    bus.en = 1'b1;
    run(2 * DG * SD);
    chk("reen_d1", seen[1], 8'h3f);

    // Mid-frame reset
    run(5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    run(DG * SD);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      bus.en       = ($urandom_range(0, 9) != 0);
      bus.load     = ($urandom_range(0, 9) == 0);
      bus.hex_in   = 16'($urandom);
      bus.dp_in    = 4'($urandom);
      bus.blank_in = 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
      rst_n        = ($urandom_range(0, 99) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hex_seg_scan.md
Name: hex_seg_scan

Overview:
- Multiplexed multi-digit 7-segment display driver: takes DIGITS hex nibbles plus per-digit decimal-point and blank flags, encodes each nibble to a 7-segment pattern, and time-scans one digit at a time.
- Sits between register/CPU logic producing hex values and the board's common-cathode segment and digit pins.
- This is the encode/drive side of the segment-pattern convention: seg[7] is dp, seg[6:0] is gfedcba.
- Double-buffered so a new value never tears mid-frame.

Parameters:
- DIGITS, default 4: number of digits scanned; must be ≥1.
- SCAN_DIV, default 50000: clock cycles per digit slot; must be ≥2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- en  in  1  scan enable
- load  in  1  one-cycle strobe; captures hex_in/dp_in/blank_in into the pending buffer
- hex_in  in  4*DIGITS  digit k nibble = hex_in[4k+3:4k]
- dp_in  in  DIGITS  decimal point per digit, 1 = lit
- blank_in  in  DIGITS  1 = digit k dark
- seg  out  8  registered segment drive, active-high; [7]=dp, [6:0]=gfedcba
- dig_sel  out  DIGITS  registered digit enable, active-low one-hot
- frame_done  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (rst_n). When rst_n=0 at a clk edge:
  - prescaler p=0, digit index i=0.
  - pending buffer cleared, pending_valid=0.
  - display buffer: hex=0, dp=0, blank=all ones.
  - Outputs: seg=8'h00, dig_sel=all ones, frame_done=0.
  - A reset mid-frame discards pending data. Reset overrides every other input.
- Encoding (combinational, hex -> seg[6:0]):
  - 0:3f, 1:06, 2:5b, 3:4f, 4:66, 5:6d, 6:7d, 7:07
  - 8:7f, 9:6f, A:77, b:7c, C:39, d:5e, E:79, F:71
- Load:
  - load=1 at an edge writes hex_in/dp_in/blank_in into the pending buffer and sets pending_valid.
  - Back-to-back loads: the last one wins.
- Scan, when en=1, each edge:
  - If p==SCAN_DIV-1: p←0 and i←(i==DIGITS-1 ? 0 : i+1). Otherwise p←p+1.
- Frame boundary: the edge where en=1, p==SCAN_DIV-1 and i==DIGITS-1.
  - frame_done←1 for exactly one cycle; otherwise frame_done←0.
  - If pending_valid, display←pending (value held before the edge).
  - pending_valid←load. A load in the boundary cycle is stored and shown one frame later.
- Outputs are registered from the pre-edge (p,i) and display buffer, i.e. 1-cycle latency. When en=1:
  - p==0: dig_sel←all ones and seg←8'h00. This is the anti-ghost dead cycle.
  - p≠0: dig_sel←~(1<<i).
    - If blank[i]: seg←8'h00.
    - Otherwise: seg←{dp[i], enc(hex[i])}.
- en=0:
  - p and i hold; frame_done←0; dig_sel←all ones; seg←8'h00.
  - If pending_valid, display←pending and pending_valid←load. No tearing is possible while dark.
  - Loads are still accepted.
  - On re-enable, scanning resumes from the held (p,i).
- Widths:
  - p is $clog2(SCAN_DIV) bits; i is $clog2(DIGITS) bits, minimum 1.
  - Comparisons use the parameter values, so non-power-of-two DIGITS wraps correctly.
- The encoder path has no default dark state: all 16 nibble values map to a lit pattern. Blanking only comes from blank bits.

Decomposition:
- Shared package seg_pkg:
  - 16-entry segment constant table (SEG_0..SEG_F).
  - SEG_OFF=8'h00 and the dp bit index (7).
- One combinational sub-module, hex_seg: 4-bit nibble in, 7-bit pattern out, using seg_pkg. Instantiated once, on the selected digit's nibble.
- Scan counters, double buffer and output registers stay in hex_seg_scan.

Test Plan (DIGITS=4, SCAN_DIV=4):
- Reset: hold rst_n=0 for 3 cycles with en=1 and load=1 → dig_sel=4'b1111, seg=8'h00, frame_done=0. After release, all slots are dark until the first load is transferred.
- Basic scan: load hex_in=16'h1234, dp_in=0, blank_in=0, en=1 → after the first frame_done, each slot shows one dead cycle then 3 cycles of:
  - dig_sel=1110 with seg=66
  - dig_sel=1101 with seg=4f
  - dig_sel=1011 with seg=5b
  - dig_sel=0111 with seg=06
  - frame_done pulses every 16 cycles.
- Encoder sweep: load each of the 16 values 0x0000..0xFFFF in turn → digit0 seg[6:0] matches the table entry for every nibble.
- Tearing: load 16'hABCD mid-frame → the current frame still shows the old value; the new value appears starting with digit0 after frame_done. A load coincident with the frame_done edge appears one frame later.
- dp/blank: hex_in=16'h8884, dp_in=4'b0101, blank_in=4'b1000 → digit0 seg=8'hE6, digit1 seg=8'h7f, digit2 seg=8'hFF, digit3 seg=8'h00 with dig_sel still 0111.
- Enable and mid-frame reset:
  - en=0 mid-slot → dig_sel=1111 the next cycle and p/i frozen. A load during en=0 is in the display buffer by re-enable. Scanning resumes at the frozen digit.
  - rst_n=0 mid-frame → all outputs at reset values after one edge.
